// File: rtl/m_7seg_scan_capture_pkg.sv
// Shared 7-segment definitions: abcdefg bit order, digit patterns and decode result type.
// The encoder (m_7segled) and the capture decoder both use these constants.
package m_7seg_scan_capture_pkg;

   localparam int SEG_W = 7;

   // abcdefg bit order, 1 = lit
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] value;
   } seg_dec_t;

   // Encode side of the same table; values above 9 show blank.
   function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] v);
      case (v)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/m_7seg_scan_capture_dec.sv
// Combinational 7-segment pattern decoder: abcdefg -> {err, blank, value}.
module m_7segdec
   import m_7seg_scan_capture_pkg::*;
(
   input  logic [SEG_W-1:0] seg_i,
   output seg_dec_t         dec_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      dec_o = '{err: 1'b0, blank: 1'b0, value: 4'h0};
      case (seg_i)
         SEG_0:     dec_o.value = 4'd0;
         SEG_1:     dec_o.value = 4'd1;
         SEG_2:     dec_o.value = 4'd2;
         SEG_3:     dec_o.value = 4'd3;
         SEG_4:     dec_o.value = 4'd4;
         SEG_5:     dec_o.value = 4'd5;
         SEG_6:     dec_o.value = 4'd6;
         SEG_7:     dec_o.value = 4'd7;
         SEG_8:     dec_o.value = 4'd8;
         SEG_9:     dec_o.value = 4'd9;
         SEG_BLANK: dec_o.blank = 1'b1;
         default: begin
            dec_o.err   = 1'b1;
            dec_o.value = 4'hF;
         end
      endcase
   end

endmodule

// File: rtl/m_7seg_scan_capture.sv
// Reads back a scanned multiplexed 7-segment display: debounces each anode dwell,
// decodes the segment pattern into the slot's digit register and reports frame completion.
module m_7seg_scan_capture
   import m_7seg_scan_capture_pkg::*;
#(
   parameter int NDIG   = 4,
   parameter int STABLE = 4
) (
   input  logic                w_clk,
   input  logic                w_rst_n,
   input  logic [SEG_W-1:0]    w_seg,
   input  logic [NDIG-1:0]     w_an,
   output logic [4*NDIG-1:0]   r_dig,
   output logic [NDIG-1:0]     r_blank,
   output logic [NDIG-1:0]     r_err,
   output logic                r_upd,
   output logic                r_frame
);

   localparam int SW = NDIG + SEG_W;
   localparam int CW = 4;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE - 1);

   logic [SW-1:0]          smp;
   logic [SW-1:0]          s_q, s_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   same;
   logic                   an_onehot;
   logic [IW-1:0]          an_idx;
   logic                   capture;
   seg_dec_t               dec;

   logic [NDIG-1:0][3:0]   dig_q, dig_d;
   logic [NDIG-1:0]        blank_q, blank_d;
   logic [NDIG-1:0]        err_q, err_d;
   logic [NDIG-1:0]        seen_q, seen_d;
   logic [NDIG-1:0]        seen_all;
   logic                   upd_q, upd_d;
   logic                   frame_q, frame_d;

   assign smp  = {w_an, w_seg};
   assign same = (smp == s_q);
   assign s_d  = smp;

   always_comb begin
      cnt_d = CNT_ONE;
      if (same) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
   end

   assign an_onehot = (w_an != '0) && ((w_an & (w_an - NDIG'(1))) == '0);

   always_comb begin
      an_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (w_an[i]) an_idx = IW'(i);
      end
   end

   // Fires on the single cycle a one-hot dwell reaches STABLE identical samples.
   assign capture = same && (cnt_q == CNT_CAP) && an_onehot;

   m_7segdec u_dec (
      .seg_i (w_seg),
      .dec_o (dec)
   );

   assign seen_all = seen_q | w_an;

   always_comb begin
      dig_d   = dig_q;
      blank_d = blank_q;
      err_d   = err_q;
      seen_d  = seen_q;
      upd_d   = capture;
      frame_d = 1'b0;
      if (capture) begin
         dig_d[an_idx]   = dec.value;
         blank_d[an_idx] = dec.blank;
         err_d[an_idx]   = dec.err;
         frame_d         = &seen_all;
         seen_d          = frame_d ? '0 : seen_all;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         s_q     <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         blank_q <= '1;
         err_q   <= '0;
         seen_q  <= '0;
         upd_q   <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         blank_q <= blank_d;
         err_q   <= err_d;
         seen_q  <= seen_d;
         upd_q   <= upd_d;
         frame_q <= frame_d;
      end
   end

   assign r_dig   = dig_q;
   assign r_blank = blank_q;
   assign r_err   = err_q;
   assign r_upd   = upd_q;
   assign r_frame = frame_q;

endmodule

// File: tb/tb_m_7seg_scan_capture.sv
// Directed bench for m_7seg_scan_capture: scans digits, glitches, error/blank patterns,
// invalid anodes, short dwells and mid-frame reset, checking every cycle.
module tb_m_7seg_scan_capture;

   logic        w_clk;
   logic        w_rst_n;
   logic [6:0]  w_seg;
   logic [3:0]  w_an;
   logic [15:0] r_dig;
   logic [3:0]  r_blank;
   logic [3:0]  r_err;
   logic        r_upd;
   logic        r_frame;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_dig;
   logic [3:0]  m_blank;
   logic [3:0]  m_err;

   m_7seg_scan_capture #(.NDIG(4), .STABLE(4)) dut (
      .w_clk   (w_clk),
      .w_rst_n (w_rst_n),
      .w_seg   (w_seg),
      .w_an    (w_an),
      .r_dig   (r_dig),
      .r_blank (r_blank),
      .r_err   (r_err),
      .r_upd   (r_upd),
      .r_frame (r_frame)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_dig"},   32'(r_dig),   32'(m_dig));
      check({tag, "_blank"}, 32'(r_blank), 32'(m_blank));
      check({tag, "_err"},   32'(r_err),   32'(m_err));
   endtask

   // Drive one dwell; called just after a rising edge. A capture is expected on
   // the 4th sampling edge (index 3) when cap is set.
   task automatic dwell(input string tag, input logic [3:0] an, input logic [6:0] seg,
                        input int ncyc, input int slot, input logic [3:0] val,
                        input logic blank, input logic err, input bit cap, input bit frm);
      bit hit;
      w_an  = an;
      w_seg = seg;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge w_clk);
         #1;
         hit = cap && (i == 3);
         if (hit) begin
            m_dig[slot*4 +: 4] = val;
            m_blank[slot]      = blank;
            m_err[slot]        = err;
         end
         check({tag, "_upd"},   32'(r_upd),   32'(hit));
         check({tag, "_frame"}, 32'(r_frame), 32'(hit && frm));
         check_state(tag);
      end
   endtask

   task automatic do_reset(input string tag);
      w_rst_n = 1'b0;
      #2;
      m_dig   = 16'h0000;
      m_blank = 4'b1111;
      m_err   = 4'b0000;
      check({tag, "_upd"},   32'(r_upd),   32'd0);
      check({tag, "_frame"}, 32'(r_frame), 32'd0);
      check_state(tag);
      w_an  = 4'b0000;
      w_seg = 7'b0000000;
      @(posedge w_clk);
      #1;
      w_rst_n = 1'b1;
   endtask

   initial begin
      w_rst_n = 1'b1;
      w_an    = 4'b0000;
      w_seg   = 7'b0000000;
      #1;
      do_reset("rst0");

      dwell("idle", 4'b0000, 7'b0000000, 6, 0, 4'h0, 1'b0, 1'b0, 0, 0);

      // Scan 3,0,4,1 into slots 0..3
      dwell("s1_0", 4'b0001, 7'b1111001, 6, 0, 4'h3, 1'b0, 1'b0, 1, 0);
      dwell("s1_1", 4'b0010, 7'b1111110, 6, 1, 4'h0, 1'b0, 1'b0, 1, 0);
      dwell("s1_2", 4'b0100, 7'b0110011, 6, 2, 4'h4, 1'b0, 1'b0, 1, 0);
      dwell("s1_3", 4'b1000, 7'b0110000, 6, 3, 4'h1, 1'b0, 1'b0, 1, 1);
      check("s1_dig", 32'(r_dig), 32'h1403);

      // Same scan with 1-cycle all-lit glitches between slots
      do_reset("rst1");
      dwell("s2_0",  4'b0001, 7'b1111001, 6, 0, 4'h3, 1'b0, 1'b0, 1, 0);
      dwell("s2_g1", 4'b0010, 7'b1111111, 1, 1, 4'h8, 1'b0, 1'b0, 0, 0);
      dwell("s2_1",  4'b0010, 7'b1111110, 6, 1, 4'h0, 1'b0, 1'b0, 1, 0);
      dwell("s2_g2", 4'b0100, 7'b1111111, 1, 2, 4'h8, 1'b0, 1'b0, 0, 0);
      dwell("s2_2",  4'b0100, 7'b0110011, 6, 2, 4'h4, 1'b0, 1'b0, 1, 0);
      dwell("s2_g3", 4'b1000, 7'b1111111, 1, 3, 4'h8, 1'b0, 1'b0, 0, 0);
      dwell("s2_3",  4'b1000, 7'b0110000, 6, 3, 4'h1, 1'b0, 1'b0, 1, 1);
      check("s2_dig", 32'(r_dig), 32'h1403);

      // Unknown pattern into slot 2, then a valid 7 overwrites it
      dwell("s3_err", 4'b0100, 7'b0000001, 5, 2, 4'hF, 1'b0, 1'b1, 1, 0);
      check("s3_err_dig", 32'(r_dig), 32'h1F03);
      check("s3_err_flag", 32'(r_err), 32'h4);
      dwell("s3_7",   4'b0100, 7'b1110000, 6, 2, 4'h7, 1'b0, 1'b0, 1, 0);
      check("s3_7_dig", 32'(r_dig), 32'h1703);

      // Multi-hot anode: no capture
      dwell("s4_inv", 4'b0110, 7'b1111111, 10, 1, 4'h8, 1'b0, 1'b0, 0, 0);

      // Dwell one sample short of STABLE: ignored
      dwell("s4_short", 4'b0010, 7'b1111011, 3, 1, 4'h9, 1'b0, 1'b0, 0, 0);
      dwell("s4_gap",   4'b0000, 7'b0000000, 2, 0, 4'h0, 1'b0, 1'b0, 0, 0);

      // Blank into slot 0, 9 into slot 1 (slots 0..2 now seen this frame)
      dwell("s4_blank", 4'b0001, 7'b0000000, 6, 0, 4'h0, 1'b1, 1'b0, 1, 0);
      dwell("s4_9",     4'b0010, 7'b1111011, 6, 1, 4'h9, 1'b0, 1'b0, 1, 0);
      check("s4_dig", 32'(r_dig), 32'h1790);
      check("s4_blank_flags", 32'(r_blank), 32'h1);

      // Mid-frame reset discards the partial frame
      do_reset("rst2");
      dwell("s5_3", 4'b1000, 7'b1011011, 6, 3, 4'h5, 1'b0, 1'b0, 1, 0);
      dwell("s5_0", 4'b0001, 7'b1101101, 6, 0, 4'h2, 1'b0, 1'b0, 1, 0);
      dwell("s5_1", 4'b0010, 7'b1011111, 6, 1, 4'h6, 1'b0, 1'b0, 1, 0);
      dwell("s5_2", 4'b0100, 7'b1111111, 6, 2, 4'h8, 1'b0, 1'b0, 1, 1);
      check("s5_dig", 32'(r_dig), 32'h5862);
      check("s5_blank_flags", 32'(r_blank), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/m_7seg_scan_capture.md
# m_7seg_scan_capture

Recovers the hex digits shown on a scanned, multiplexed 7-segment display by observing its segment and anode lines. It is the reading end of the segment encoding produced by `m_7segled`: it samples the `abcdefg` bus on each anode slot, rejects scan-transition glitches, and decodes each segment pattern back to a 4-bit value. It is used in self-checking display benches and for readback on the board.

## Interface
- `NDIG`, 4: number of multiplexed digits, which is also the anode bus width.
- `STABLE`, 4: number of consecutive identical samples required before a capture. Legal range 2..15.

Ports:
- `w_clk` input, 1: system clock, rising edge.
- `w_rst_n` input, 1: asynchronous, active-low reset.
- `w_seg` input, 7: segment bus `abcdefg`; bit 6 = a, bit 0 = g; 1 = lit.
- `w_an` input, `NDIG`: digit select, active-high, one-hot when valid.
- `r_dig` output, 4*`NDIG`: decoded digits; slot i is at bits [4i+3:4i].
- `r_blank` output, `NDIG`: slot i last captured the blank pattern `0000000`.
- `r_err` output, `NDIG`: slot i last captured a pattern that is neither a digit nor blank.
- `r_upd` output, 1: one-cycle pulse on every capture.
- `r_frame` output, 1: one-cycle pulse when every slot has been captured since the previous frame.

## Operation
- Decode table (pattern → value):
  - 0 `1111110`, 1 `0110000`, 2 `1101101`, 3 `1111001`, 4 `0110011`
  - 5 `1011011`, 6 `1011111`, 7 `1110000`, 8 `1111111`, 9 `1111011`
  - blank `0000000` → value 0, blank flag = 1
  - any other pattern → value 4'hF, err flag = 1
- Sample register `s` holds {`w_an`, `w_seg`} from the previous edge. On each edge:
  - `s` ← current input.
  - If current input == `s`: `cnt` ← min(`cnt`+1, `STABLE`). Otherwise `cnt` ← 1.
- Capture condition: current input == `s`, `cnt` == `STABLE`-1, and `w_an` is one-hot. This fires exactly once per stable dwell; `cnt` then saturates and no re-capture occurs.
- On capture into slot i (the index of the set anode bit):
  - Write `r_dig`[i], `r_blank`[i] and `r_err`[i] from the decode.
  - Set `seen`[i]. Assert `r_upd` for one cycle.
- Frame completion:
  - If `seen` including the current capture is all-ones: `r_frame` pulses in the same cycle as `r_upd`, and `seen` clears to 0.
  - Recapturing a slot before the frame completes overwrites its value and does not advance the frame.
- Invalid anode (all-zero or multi-hot):
  - Counting continues, but capture is suppressed.
  - A dwell that later becomes one-hot restarts counting, because the input changed.
- Slots not being captured hold their values indefinitely.

## Timing
- Reset values:
  - `r_dig` = 0, `r_blank` = all-ones, `r_err` = 0, `r_upd` = 0, `r_frame` = 0.
  - Internal: `seen` = 0, `cnt` = 0, `s` = 0.
- Latency: if the input first takes a new value at sample edge k and then holds, outputs update at edge k+`STABLE`-1. With `STABLE`=4 this is edge k+3.
- Dwells shorter than `STABLE` samples are ignored entirely. This includes a 1-cycle glitch between scan slots.
- Reset asserted mid-frame: all state clears immediately, the partial frame is discarded, and there is no `r_frame` pulse.
- `r_upd`/`r_frame` are registered, have no back-pressure, and are not held.

## Structure
- Shared Verilog header holds:
  - Segment pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`. `m_7segled` migrates to these constants so the encode and decode sides cannot drift.
  - The `abcdefg` bit-order definition.
- Sub-module `m_7segdec`: purely combinational, 7-bit pattern → {err, blank, value[3:0]}.
- Top level contains the sample register, stability counter, one-hot check with index encoder, slot registers and `seen` tracking.

## Test plan
- Reset, then idle with `w_an`=0:
  - Response: `r_dig`=0, `r_blank`=4'b1111, no pulses.
- Scan `w_an`=0001/0010/0100/1000 with patterns for 3,0,4,1, each held 6 cycles:
  - Response: `r_dig`=16'h1403, four `r_upd` pulses, one `r_frame` pulse coinciding with the slot-3 capture.
  - Each capture occurs exactly 3 edges after its dwell begins.
- Same scan, but with 1-cycle `1111111` glitches inserted between slots:
  - Response: no capture of 8, and results identical to the previous scenario.
- Slot 2 held with `0000001` for 5 cycles:
  - Response: `r_err`[2]=1, `r_dig`[11:8]=4'hF.
  - A later capture of 7 into slot 2 clears `r_err`[2] and sets the slot to 7.
- `w_an`=0110 held 10 cycles with any pattern:
  - Response: no `r_upd` pulse and no state change.
- Assert `w_rst_n` after slots 0..2 are captured, then complete a full scan:
  - Response: all outputs return to their reset values, and `r_frame` fires only after all four slots are captured after reset.
